// File: rtl/numa_sched_pkg.sv
// Shared widths and index arithmetic for the NUMA crossbar scheduler.
// Latency: none (functions only).
// Backpressure: n/a.
package numa_sched_pkg;

    // Width of an index into n entries; never below one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Width able to hold the values 0..max_val inclusive.
    function automatic int cnt_width(input int max_val);
        return (max_val > 0) ? $clog2(max_val + 1) : 1;
    endfunction

    // Next index after idx, wrapping at n so non-power-of-two sizes never
    // produce an out-of-range pointer.
    function automatic int wrap_inc(input int idx, input int n);
        return (idx >= n - 1) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/numa_ostd_counter.sv
// Per-master outstanding-transaction throttle and starvation timer.
// Latency: gating reacts one cycle after the count changes; urgent is registered.
// Backpressure: req is masked while cnt==MaxOutstanding; rsp_* never reach xreq_o combinationally.
module numa_ostd_counter
    import numa_sched_pkg::*;
#(
    parameter int MaxOutstanding = 4,
    parameter int StarveThresh   = 8
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic req_i,
    input  logic xgnt_i,
    input  logic rsp_vld_i,
    input  logic rsp_rdy_i,
    output logic xreq_o,
    output logic busy_o,
    output logic urgent_o,
    output logic err_o
);
    localparam int CW = cnt_width(MaxOutstanding);
    localparam int WW = cnt_width(StarveThresh);

    logic [CW-1:0] cnt_q, cnt_d;
    logic [WW-1:0] wait_q, wait_d;
    logic          err_q, err_d;
    logic          issue, retire;

    // Gate only on the registered count so responses cannot race into xreq_o.
    assign xreq_o   = req_i & (cnt_q < CW'(MaxOutstanding));
    assign issue    = xreq_o & xgnt_i;
    assign retire   = rsp_vld_i & rsp_rdy_i;
    assign busy_o   = (cnt_q != '0);
    assign urgent_o = (wait_q == WW'(StarveThresh));
    assign err_o    = err_q;

    // Next-state for the outstanding count, underflow flag and starvation timer.
    always_comb begin
        cnt_d  = cnt_q;
        err_d  = err_q;
        wait_d = wait_q;
        case ({issue, retire})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01: begin
                if (cnt_q == '0) begin
                    err_d = 1'b1;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            2'b11: begin
                // Net count unchanged, but a response with nothing in flight is still bogus.
                if (cnt_q == '0) begin
                    err_d = 1'b1;
                end
            end
            default: ;
        endcase
        // A throttled master has xreq_o low, so it never accumulates wait.
        if (!xreq_o || issue) begin
            wait_d = '0;
        end else if (wait_q != WW'(StarveThresh)) begin
            wait_d = wait_q + 1'b1;
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            cnt_q  <= '0;
            wait_q <= '0;
            err_q  <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            wait_q <= wait_d;
            err_q  <= err_d;
        end
    end

endmodule

// File: rtl/numa_xbar_sched.sv
// Priority-pointer scheduler and outstanding throttle in front of the NUMA request crossbar.
// Latency: rr_o updates one cycle after a handshake or urgent condition; xreq_o/gnt_o are combinational.
// Backpressure: a master at its outstanding cap sees xreq_o low until a retire lowers the count.
module numa_xbar_sched
    import numa_sched_pkg::*;
#(
    parameter int NumIn          = 4,
    parameter int NumOut         = 4,
    parameter int MaxOutstanding = 4,
    parameter int StarveThresh   = 8
) (
    input  logic                                 clk_i,
    input  logic                                 rst_ni,
    input  logic [NumIn-1:0]                     req_i,
    input  logic [NumIn*idx_width(NumOut)-1:0]   add_i,
    output logic [NumIn-1:0]                     gnt_o,
    output logic [NumIn-1:0]                     xreq_o,
    input  logic [NumIn-1:0]                     xgnt_i,
    output logic [NumOut*idx_width(NumIn)-1:0]   rr_o,
    input  logic [NumOut-1:0]                    tgt_req_i,
    input  logic [NumOut-1:0]                    tgt_gnt_i,
    input  logic [NumOut*idx_width(NumIn)-1:0]   tgt_idx_i,
    input  logic [NumIn-1:0]                     rsp_vld_i,
    input  logic [NumIn-1:0]                     rsp_rdy_i,
    output logic [NumIn-1:0]                     busy_o,
    output logic [NumIn-1:0]                     urgent_o,
    output logic                                 err_o
);
    localparam int IW = idx_width(NumIn);
    localparam int AW = idx_width(NumOut);

    logic [NumOut*IW-1:0] rr_q, rr_d;
    logic [NumOut-1:0]    ovr_hit;
    logic [NumIn-1:0]     uf;

    for (genvar m = 0; m < NumIn; m++) begin : g_master
        numa_ostd_counter #(
            .MaxOutstanding (MaxOutstanding),
            .StarveThresh   (StarveThresh)
        ) u_cnt (
            .clk_i     (clk_i),
            .rst_ni    (rst_ni),
            .req_i     (req_i[m]),
            .xgnt_i    (xgnt_i[m]),
            .rsp_vld_i (rsp_vld_i[m]),
            .rsp_rdy_i (rsp_rdy_i[m]),
            .xreq_o    (xreq_o[m]),
            .busy_o    (busy_o[m]),
            .urgent_o  (urgent_o[m]),
            .err_o     (uf[m])
        );
    end

    assign gnt_o = xgnt_i & xreq_o;
    assign err_o = |uf;
    assign rr_o  = rr_q;

    // Per-target pointer: urgent override (lowest master wins), else advance past the served master, else hold.
    always_comb begin
        rr_d    = rr_q;
        ovr_hit = '0;
        for (int t = 0; t < NumOut; t++) begin
            // Descending scan so the lowest matching master is written last.
            for (int m = NumIn - 1; m >= 0; m--) begin
                if (urgent_o[m] && xreq_o[m] && (add_i[m*AW +: AW] == AW'(t))) begin
                    ovr_hit[t]         = 1'b1;
                    rr_d[t*IW +: IW]   = IW'(m);
                end
            end
            if (!ovr_hit[t] && tgt_req_i[t] && tgt_gnt_i[t]) begin
                rr_d[t*IW +: IW] = IW'(wrap_inc(int'(tgt_idx_i[t*IW +: IW]), NumIn));
            end
        end
    end

    // Pointer register with synchronous active-low reset.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            rr_q <= '0;
        end else begin
            rr_q <= rr_d;
        end
    end

endmodule
